// File: rtl/fsbm_seq_ctr.sv
// Control sequencer for the full-search block-matching datapath: INIT, then ROUNDS x (LOAD, FILL, RUN), then DONE.
// Optional macro FSBM_SEQ_STALL_EN lets stall freeze the LOAD/FILL/RUN phases.
module fsbm_seq_ctr #(
   parameter int WORD_WIDTH  = 8,
   parameter int LANES       = 4,
   parameter int INIT_CYCLES = 73,
   parameter int LOAD_CYCLES = 4,
   parameter int FILL_CYCLES = 5,
   parameter int PE_CYCLES   = 15,
   parameter int ROUNDS      = 16,
   parameter int CW_WIDTH    = 4,
   parameter int RI_WIDTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stall,
   input  logic [WORD_WIDTH*LANES-1:0] input_raw,
   output logic [WORD_WIDTH*LANES-1:0] input_raw_saved,
   output logic [CW_WIDTH-1:0]         ctr_word,
   output logic                        mem_search_en_input,
   output logic                        mem_ref_en_input,
   output logic                        mem_res_en_input,
   output logic                        mem_init_mode,
   output logic                        en_pe,
   output logic [RI_WIDTH-1:0]         round_idx,
   output logic                        busy,
   output logic                        done
);

   localparam int M1     = (INIT_CYCLES > PE_CYCLES) ? INIT_CYCLES : PE_CYCLES;
   localparam int M2     = (LOAD_CYCLES > FILL_CYCLES) ? LOAD_CYCLES : FILL_CYCLES;
   localparam int MAX_PH = (M1 > M2) ? M1 : M2;
   localparam int CNT_W  = $clog2(MAX_PH + 1);

   localparam logic [CNT_W-1:0]    INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]    LOAD_LAST  = CNT_W'((LOAD_CYCLES > 0) ? LOAD_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]    FILL_LAST  = CNT_W'((FILL_CYCLES > 0) ? FILL_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]    PE_LAST    = CNT_W'(PE_CYCLES - 1);
   localparam logic [RI_WIDTH-1:0] LAST_ROUND = RI_WIDTH'(ROUNDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_FILL, S_RUN, S_DONE} state_t;

   // Zero-length LOAD/FILL phases are skipped by choosing the entry state statically.
   localparam state_t ROUND_ST  = (LOAD_CYCLES > 0) ? S_LOAD : ((FILL_CYCLES > 0) ? S_FILL : S_RUN);
   localparam state_t POST_LOAD = (FILL_CYCLES > 0) ? S_FILL : S_RUN;

   state_t              st, nxt_st;
   logic [CNT_W-1:0]    cnt, nxt_cnt;
   logic [RI_WIDTH-1:0] nxt_round;
   logic                res_d;
   logic                srch_q, ref_q, res_q, pe_q;
   logic                stall_eff;

`ifdef FSBM_SEQ_STALL_EN
   assign stall_eff = stall && (st == S_LOAD || st == S_FILL || st == S_RUN);
`else
   logic unused_stall;
   assign unused_stall = stall;
   assign stall_eff    = 1'b0;
`endif

   always_comb begin
      nxt_st    = st;
      nxt_cnt   = cnt + CNT_W'(1);
      nxt_round = round_idx;
      res_d     = 1'b0;
      case (st)
         S_IDLE: begin
            nxt_cnt = '0;
            if (start) nxt_st = S_INIT;
         end
         S_INIT:
            if (cnt == INIT_LAST) begin
               nxt_st    = ROUND_ST;
               nxt_cnt   = '0;
               nxt_round = '0;
            end
         S_LOAD:
            if (cnt == LOAD_LAST) begin
               nxt_st  = POST_LOAD;
               nxt_cnt = '0;
            end
         S_FILL:
            if (cnt == FILL_LAST) begin
               nxt_st  = S_RUN;
               nxt_cnt = '0;
            end
         S_RUN:
            if (cnt == PE_LAST) begin
               nxt_cnt = '0;
               res_d   = 1'b1;
               if (round_idx == LAST_ROUND) begin
                  nxt_st = S_DONE;
               end else begin
                  nxt_st    = ROUND_ST;
                  nxt_round = round_idx + RI_WIDTH'(1);
               end
            end
         default: begin
            nxt_st    = S_IDLE;
            nxt_cnt   = '0;
            nxt_round = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st              <= S_IDLE;
         cnt             <= '0;
         round_idx       <= '0;
         input_raw_saved <= '0;
         ctr_word        <= '0;
         mem_init_mode   <= 1'b0;
         srch_q          <= 1'b0;
         ref_q           <= 1'b0;
         res_q           <= 1'b0;
         pe_q            <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else if (!stall_eff) begin
         st              <= nxt_st;
         cnt             <= nxt_cnt;
         round_idx       <= nxt_round;
         input_raw_saved <= input_raw;
         ctr_word        <= (nxt_st == S_RUN) ? CW_WIDTH'(nxt_cnt) + CW_WIDTH'(1) : '0;
         mem_init_mode   <= (nxt_st == S_INIT);
         srch_q          <= (nxt_st == S_INIT) || (nxt_st == S_FILL) ||
                            ((nxt_st == S_RUN) && (nxt_cnt != PE_LAST));
         ref_q           <= (nxt_st == S_LOAD);
         res_q           <= res_d;
         pe_q            <= (nxt_st == S_RUN);
         busy            <= (nxt_st != S_IDLE);
         done            <= (nxt_st == S_DONE);
      end
   end

   // A stalled cycle keeps its strobes registered, so a held result strobe reappears once stall drops.
   assign en_pe               = pe_q   & ~stall_eff;
   assign mem_search_en_input = srch_q & ~stall_eff;
   assign mem_ref_en_input    = ref_q  & ~stall_eff;
   assign mem_res_en_input    = res_q  & ~stall_eff;

endmodule

// File: tb/tb_fsbm_seq_ctr.sv
// Bench for fsbm_seq_ctr: default instance plus a ROUNDS=1/LOAD_CYCLES=0 instance, against a schedule-position model.
module tb_fsbm_seq_ctr;
`ifdef FSBM_SEQ_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] saved;
      logic [3:0]  ctr;
      logic        srch, refe, res, init, pe;
      logic [3:0]  round;
      logic        busy, done;
   } obs_t;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0;
   logic [31:0] input_raw = '0;
   always #5 clk = ~clk;

   logic [31:0] sv1_w, sv2_w;
   logic [3:0]  ctr1, ctr2, rnd1, rnd2;
   logic        srch1, ref1, res1, init1, pe1, busy1, done1;
   logic        srch2, ref2, res2, init2, pe2, busy2, done2;
   obs_t        o1, o2;
   assign o1 = {sv1_w, ctr1, srch1, ref1, res1, init1, pe1, rnd1, busy1, done1};
   assign o2 = {sv2_w, ctr2, srch2, ref2, res2, init2, pe2, rnd2, busy2, done2};

   fsbm_seq_ctr dut1 (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .input_raw(input_raw),
      .input_raw_saved(sv1_w), .ctr_word(ctr1), .mem_search_en_input(srch1),
      .mem_ref_en_input(ref1), .mem_res_en_input(res1), .mem_init_mode(init1),
      .en_pe(pe1), .round_idx(rnd1), .busy(busy1), .done(done1));

   fsbm_seq_ctr #(.INIT_CYCLES(5), .LOAD_CYCLES(0), .FILL_CYCLES(2), .PE_CYCLES(3), .ROUNDS(1)) dut2 (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .input_raw(input_raw),
      .input_raw_saved(sv2_w), .ctr_word(ctr2), .mem_search_en_input(srch2),
      .mem_ref_en_input(ref2), .mem_res_en_input(res2), .mem_init_mode(init2),
      .en_pe(pe2), .round_idx(rnd2), .busy(busy2), .done(done2));

   int          total = 0, bad = 0, cyc_n = 0, done1_n = 0;
   bit          act1 = 0, act2 = 0;
   int          p1 = 0, p2 = 0;
   logic [31:0] sv1 = '0, sv2 = '0;

   // p = count of advancing cycles since start; phase derived arithmetically from the schedule.
   function automatic obs_t mdl(input int ic, input int lc, input int fc, input int pc, input int rn,
                                input bit act, input int p, input bit stl, input logic [31:0] sv,
                                output bit seff, output bit is_done);
      obs_t e;
      int per, q, r, o, step, ph;
      per = lc + fc + pc; r = 0; o = 0; step = 0;
      if (!act) ph = 0;
      else if (p < ic) ph = 1;
      else begin
         q = p - ic;
         if (q >= rn * per) ph = 5;
         else begin
            r = q / per; o = q % per;
            if (o < lc) ph = 2;
            else if (o < lc + fc) ph = 3;
            else begin ph = 4; step = o - lc - fc + 1; end
         end
      end
      seff    = STALL_EN && stl && (ph >= 2 && ph <= 4);
      is_done = (ph == 5);
      e       = '0;
      e.saved = sv;
      e.busy  = (ph != 0);
      e.done  = (ph == 5);
      e.init  = (ph == 1);
      e.refe  = (ph == 2) && !seff;
      e.pe    = (ph == 4) && !seff;
      e.srch  = ((ph == 1) || (ph == 3) || (ph == 4 && step != pc)) && !seff;
      e.ctr   = (ph == 4) ? 4'(step) : 4'd0;
      e.round = (ph == 5) ? 4'(rn - 1) : 4'(r);
      e.res   = ((ph == 5) || ((ph >= 2 && ph <= 4) && o == 0 && p > ic)) && !seff;
      return e;
   endfunction

   function automatic obs_t peek1();
      bit a, b;
      return mdl(73, 4, 5, 15, 16, act1, p1, 1'b0, sv1, a, b);
   endfunction

   task automatic chk_o(input string tag, input obs_t got, input obs_t exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step_cycle(input bit st, input bit sl);
      obs_t e;
      bit   se, dn;
      @(negedge clk);
      start = st; stall = sl; input_raw = $urandom; #1;
      e = mdl(73, 4, 5, 15, 16, act1, p1, sl, sv1, se, dn);
      chk_o("dut1", o1, e);
      if (o1.done) done1_n++;
      if (!act1) begin if (st) begin act1 = 1; p1 = 0; end end
      else if (!se) begin if (dn) act1 = 0; else p1++; end
      if (!se) sv1 = input_raw;
      e = mdl(5, 0, 2, 3, 1, act2, p2, sl, sv2, se, dn);
      chk_o("dut2", o2, e);
      if (!act2) begin if (st) begin act2 = 1; p2 = 0; end end
      else if (!se) begin if (dn) act2 = 0; else p2++; end
      if (!se) sv2 = input_raw;
      cyc_n++;
   endtask

   task automatic do_reset();
      start = 0; stall = 0; input_raw = '0;
      #2 rst = 1'b1; #1;
      chk_o("rst1", o1, '0);
      chk_o("rst2", o2, '0);
      act1 = 0; act2 = 0; p1 = 0; p2 = 0; sv1 = '0; sv2 = '0;
      @(negedge clk); rst = 1'b0;
   endtask

   // mode: 0 plain, 1 three-cycle stall at ctr_word=5, 2 random stall, 3 start pulse during RUN
   task automatic run(input int mode, output int lat, output int lat2);
      int   c0, stall_left;
      bit   hit, sl, st;
      obs_t e;
      hit = 0; stall_left = 0; lat = -1; lat2 = -1;
      step_cycle(1'b1, 1'b0);
      c0 = cyc_n - 1;
      for (int n = 0; n < 3000 && lat < 0; n++) begin
         sl = 0; st = 0;
         e  = peek1();
         case (mode)
            1: if (!hit && e.ctr == 4'd5) begin hit = 1; stall_left = 3; end
            2: sl = ($urandom_range(0, 3) == 0);
            3: st = (e.ctr == 4'd7 && e.round == 4'd2);
            default: ;
         endcase
         if (stall_left > 0) begin sl = 1; stall_left--; end
         step_cycle(st, sl);
         if (o2.done && lat2 < 0) lat2 = cyc_n - 1 - c0;
         if (o1.done) lat = cyc_n - 1 - c0;
      end
      repeat (3) step_cycle(1'b0, 1'b0);
   endtask

   initial begin
      int   lat, lat2, d0;
      bit   found;
      obs_t e;
      do_reset();
      repeat (2) step_cycle(1'b0, 1'b0);

      run(0, lat, lat2);
      chk_i("lat_plain", lat, 458);
      chk_i("lat_dut2", lat2, 11);

      d0 = done1_n;
      run(3, lat, lat2);
      chk_i("lat_start_in_run", lat, 458);
      chk_i("one_done", done1_n - d0, 1);

      run(1, lat, lat2);
      chk_i("lat_stall", lat, STALL_EN ? 461 : 458);

      d0 = done1_n;
      run(2, lat, lat2);
      chk_i("rand_stall_done", done1_n - d0, 1);

      step_cycle(1'b1, 1'b0);
      found = 0;
      for (int n = 0; n < 1000 && !found; n++) begin
         e = peek1();
         if (e.round == 4'd7 && e.ctr == 4'd9) found = 1;
         else step_cycle(1'b0, 1'b0);
      end
      chk_i("reach_r7c9", int'(found), 1);
      step_cycle(1'b0, 1'b0);
      do_reset();
      d0 = done1_n;
      repeat (600) step_cycle(1'b0, 1'b0);
      chk_i("no_done_after_rst", done1_n - d0, 0);
      run(0, lat, lat2);
      chk_i("lat_restart", lat, 458);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
